// File: rtl/uart_tx_fifo_serial.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_serial
//
// Purpose
//   Byte FIFO followed by an 8N1 UART serializer (LSB first). Bytes arrive on
//   a valid-only push interface from an upstream line feeder. That feeder
//   pushes a whole text line on consecutive clocks and never looks at ready
//   per byte. o_tx_ready therefore advertises "a full line fits" rather than
//   "one byte fits".
//
// Parameters
//   FCLK_HZ     system clock frequency in Hz
//   BAUD        serial line rate; DIV = round(FCLK_HZ / BAUD) clocks per bit
//   FIFO_DEPTH  byte entries, power of two, >= READY_ROOM
//   READY_ROOM  free entries required before o_tx_ready is raised
//
// Ports
//   i_clk_20mhz      in   system clock, all logic on the rising edge
//   i_rst_20mhz      in   asynchronous active-high reset
//   i_tx_data        in   [7:0] byte to enqueue, ignored unless i_tx_valid
//   i_tx_valid       in   enqueue strobe, at most one byte per clock
//   o_tx_ready       out  registered; free entries >= READY_ROOM
//   o_uart_tx        out  registered serial line, idle high
//   o_tx_busy        out  registered; FIFO non-empty or a frame in progress
//   o_fifo_overflow  out  sticky; a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_fifo_serial #(
   parameter int unsigned FCLK_HZ    = 20_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned READY_ROOM = 34
) (
   input  logic       i_clk_20mhz,
   input  logic       i_rst_20mhz,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic       o_uart_tx,
   output logic       o_tx_busy,
   output logic       o_fifo_overflow
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int unsigned DIV = (FCLK_HZ + BAUD / 2) / BAUD;   // clocks per bit
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);           // pointer width
   localparam int unsigned CW  = AW + 1;                       // count 0..DEPTH
   localparam int unsigned BW  = $clog2(DIV);                  // holds 0..DIV-1

   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ROOM_C    = CW'(READY_ROOM);
   localparam logic [CW-1:0] COUNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   state_t        state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic          baud_term;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          frame_next;
   logic [7:0]    head;

   assign baud_term  = (baud_cnt == BAUD_LAST);
   assign fifo_full  = (count == DEPTH_C);
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];

   // A push is judged on the registered count only. A pop on the same edge
   // frees a slot too late to rescue a push that arrives while full.
   assign push = i_tx_valid && !fifo_full;

   // The serializer consumes a byte either from IDLE or at the very end of a
   // stop bit. The second case chains frames with no idle gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && baud_term));

   // A frame is running after this edge if a byte is popped now, or if a
   // frame is running and this is not the final clock of its stop bit.
   assign frame_next = pop ||
                       ((state != IDLE) && !((state == STOP) && baud_term));

   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + COUNT_ONE;
         2'b01:   count_next = count - COUNT_ONE;
         default: count_next = count;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO bookkeeping and registered status flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         o_tx_ready      <= 1'b0;
         o_tx_busy       <= 1'b0;
         o_fifo_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;

         // Flags describe the FIFO as it will be after this edge. The
         // subtraction cannot underflow because count_next never exceeds
         // DEPTH.
         o_tx_ready <= ((DEPTH_C - count_next) >= ROOM_C);
         o_tx_busy  <= (count_next != '0) || frame_next;

         if (i_tx_valid && fifo_full) begin
            o_fifo_overflow <= 1'b1;
         end
      end
   end

   // NOTE: the byte array has no reset; its contents are meaningless until written and the pointers guard them.
   always_ff @(posedge i_clk_20mhz) begin
      if (push) begin
         mem[wr_ptr] <= i_tx_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Serializer: IDLE -> START -> DATA x8 -> STOP -> (START | IDLE)
   // Every bit lasts DIV clocks. The line value is set on the edge that enters
   // each bit, so o_uart_tx is a flop output with no decode glitches.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         o_uart_tx <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift     <= head;
                  o_uart_tx <= 1'b0;
                  baud_cnt  <= '0;
                  state     <= START;
               end
            end

            START: begin
               if (baud_term) begin
                  o_uart_tx <= shift[0];
                  bit_idx   <= '0;
                  baud_cnt  <= '0;
                  state     <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (baud_term) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     o_uart_tx <= 1'b1;
                     state     <= STOP;
                  end else begin
                     // Shift right so the next bit to send always sits at
                     // shift[1] while the current one is on the line.
                     shift     <= {1'b0, shift[7:1]};
                     o_uart_tx <= shift[1];
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               if (baud_term) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift     <= head;
                     o_uart_tx <= 1'b0;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               baud_cnt  <= '0;
               o_uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_serial.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_serial
//
// Bench for uart_tx_fifo_serial at its default parameters (DIV = 174).
// The reference model keeps a byte queue and the current frame's age in
// clocks. The expected line level is read off the frame age (age / DIV picks
// the start, data or stop bit). The model is checked against the DUT on every
// clock. Directed sequences add literal timing checks taken from hand
// calculations.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_serial;

   localparam int DIV   = 174;
   localparam int FRAME = 10 * DIV;
   localparam int DEPTH = 64;
   localparam int ROOM  = 34;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       tx_ready;
   logic       uart_tx;
   logic       tx_busy;
   logic       fifo_overflow;

   always #25 clk = ~clk;

   uart_tx_fifo_serial dut (
      .i_clk_20mhz     (clk),
      .i_rst_20mhz     (rst),
      .i_tx_data       (data),
      .i_tx_valid      (valid),
      .o_tx_ready      (tx_ready),
      .o_uart_tx       (uart_tx),
      .o_tx_busy       (tx_busy),
      .o_fifo_overflow (fifo_overflow)
   );

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [7:0]  mq[$];
   bit          m_active = 1'b0;
   int          m_age    = 0;
   logic [7:0]  m_byte   = 8'h00;
   bit          m_ovf    = 1'b0;
   bit          m_ready  = 1'b0;
   int          m_pre;
   int          m_idx;
   bit          m_push_ok;
   logic        m_line;
   int unsigned fall_q[$];
   logic        prev_line = 1'b1;
   logic        prev_ovf  = 1'b0;
   int unsigned ovf_rise  = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mq.delete();
         m_active = 1'b0;
         m_age    = 0;
         m_ovf    = 1'b0;
         m_ready  = 1'b0;
      end else begin
         m_pre     = mq.size();
         m_push_ok = valid && (m_pre < DEPTH);
         if (m_active) begin
            m_age++;
            if (m_age == FRAME) m_active = 1'b0;
         end
         if (!m_active && m_pre > 0) begin
            m_byte   = mq.pop_front();
            m_active = 1'b1;
            m_age    = 0;
         end
         if (m_push_ok) mq.push_back(data);
         else if (valid) m_ovf = 1'b1;
         m_ready = (DEPTH - mq.size()) >= ROOM;
      end
      #1;
      if (m_active) begin
         m_idx  = m_age / DIV;
         m_line = (m_idx == 0) ? 1'b0 : (m_idx == 9) ? 1'b1 : m_byte[m_idx-1];
      end else begin
         m_line = 1'b1;
      end
      check("uart_tx", {31'b0, uart_tx}, {31'b0, m_line});
      check("tx_ready", {31'b0, tx_ready}, {31'b0, m_ready});
      check("tx_busy", {31'b0, tx_busy}, {31'b0, (mq.size() > 0) || m_active});
      check("overflow", {31'b0, fifo_overflow}, {31'b0, m_ovf});
      if (prev_line && !uart_tx) fall_q.push_back(cyc);
      prev_line = uart_tx;
      if (fifo_overflow && !prev_ovf) ovf_rise = cyc;
      prev_ovf = fifo_overflow;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ---------------------------------------------------------------------------
   task automatic idle_inputs();
      valid = 1'b0;
      data  = 8'($urandom);
   endtask

   // Stop on the falling edge that follows rising edge n.
   task automatic at_edge(input int unsigned n);
      if (n < cyc) check("schedule", cyc, n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push_bytes(input logic [7:0] b[$], output int unsigned k);
      k = 0;
      foreach (b[i]) begin
         @(negedge clk);
         if (i == 0) k = cyc + 1;
         valid = 1'b1;
         data  = b[i];
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      check("rst_line", {31'b0, uart_tx}, 32'd1);
      check("rst_ready", {31'b0, tx_ready}, 32'd0);
      check("rst_busy", {31'b0, tx_busy}, 32'd0);
      check("rst_ovf", {31'b0, fifo_overflow}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'b0, tx_ready}, 32'd1);
      ovf_rise = 0;
      fall_q.delete();
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequences
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0]  bq[$];
      logic [9:0]  pat;
      int unsigned k;
      int unsigned d;

      idle_inputs();
      repeat (3) @(negedge clk);
      do_reset();

      // 1: single 0x55 frame, bit-level timing
      bq  = '{8'h55};
      push_bytes(bq, k);
      pat = 10'b1010101010;
      at_edge(k);
      check("t1_line_at_push", {31'b0, uart_tx}, 32'd1);
      at_edge(k + 1);
      check("t1_line_fall", {31'b0, uart_tx}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         at_edge(k + 1 + DIV * i + DIV / 2);
         check("t1_bit", {31'b0, uart_tx}, {31'b0, pat[i]});
      end
      at_edge(k + FRAME);
      check("t1_busy_last", {31'b0, tx_busy}, 32'd1);
      at_edge(k + 1 + FRAME);
      check("t1_busy_drop", {31'b0, tx_busy}, 32'd0);

      // 2: 34-byte line, ready threshold and gapless frames
      do_reset();
      k = 0;
      for (int j = 0; j < 34; j++) begin
         @(negedge clk);
         if (j == 0) k = cyc + 1;
         if (cyc == k + 30) check("t2_ready_cnt30", {31'b0, tx_ready}, 32'd1);
         if (cyc == k + 31) check("t2_ready_cnt31", {31'b0, tx_ready}, 32'd0);
         valid = 1'b1;
         data  = (j < 32) ? 8'(8'h41 + j) : ((j == 32) ? 8'h0D : 8'h0A);
      end
      @(negedge clk);
      idle_inputs();
      at_edge(k + 1 + DIV + DIV / 2);
      check("t2_first_bit0", {31'b0, uart_tx}, 32'd1);
      at_edge(k + 5220);
      check("t2_ready_cnt31b", {31'b0, tx_ready}, 32'd0);
      at_edge(k + 5221);
      check("t2_ready_cnt30b", {31'b0, tx_ready}, 32'd1);
      at_edge(k + 34 * FRAME);
      check("t2_busy_last", {31'b0, tx_busy}, 32'd1);
      at_edge(k + 1 + 34 * FRAME);
      check("t2_busy_drop", {31'b0, tx_busy}, 32'd0);
      check("t2_frames", fall_q.size() > 0 ? 32'(fall_q[0]) : 32'd0, k + 1);

      // 6: 0x00 then 0xFF back to back
      do_reset();
      bq = '{8'h00, 8'hFF};
      push_bytes(bq, k);
      at_edge(k + 1 + 9 * DIV - 1);
      check("t6_bit7", {31'b0, uart_tx}, 32'd0);
      at_edge(k + 1 + 9 * DIV);
      check("t6_stop_first", {31'b0, uart_tx}, 32'd1);
      at_edge(k + FRAME);
      check("t6_stop_last", {31'b0, uart_tx}, 32'd1);
      at_edge(k + 1 + FRAME);
      d = (fall_q.size() >= 2) ? fall_q[1] - fall_q[0] : 0;
      check("t6_start_spacing", d, FRAME);
      check("t6_fall_count", fall_q.size(), 2);
      at_edge(k + 1 + 2 * FRAME);
      check("t6_busy_drop", {31'b0, tx_busy}, 32'd0);

      // 5: reset in the middle of frame 3 of a 10-byte burst
      do_reset();
      bq.delete();
      for (int i = 0; i < 10; i++) bq.push_back(8'(8'h30 + i));
      push_bytes(bq, k);
      at_edge(k + 1 + 2 * FRAME + 600);
      #5 rst = 1'b1;
      #1;
      check("t5_line_async", {31'b0, uart_tx}, 32'd1);
      check("t5_busy_async", {31'b0, tx_busy}, 32'd0);
      check("t5_ready_async", {31'b0, tx_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fall_q.delete();
      at_edge(cyc + 3000);
      check("t5_no_resend", fall_q.size(), 0);
      check("t5_idle_busy", {31'b0, tx_busy}, 32'd0);
      bq = '{8'hA5};
      push_bytes(bq, k);
      at_edge(k + 1);
      check("t5_new_fall", {31'b0, uart_tx}, 32'd0);
      at_edge(k + 1 + FRAME);
      check("t5_new_done", {31'b0, tx_busy}, 32'd0);

      // 3: 70 consecutive pushes into an idle FIFO
      do_reset();
      bq.delete();
      for (int i = 0; i < 70; i++) bq.push_back(8'(8'h80 + i));
      push_bytes(bq, k);
      check("t3_ovf_edge", ovf_rise, k + 65);
      check("t3_ready_full", {31'b0, tx_ready}, 32'd0);
      at_edge(k + 1 + 2 * FRAME + 10);
      check("t3_ovf_sticky", {31'b0, fifo_overflow}, 32'd1);

      // 4: push on the edge where a stop bit ends and pops from a full FIFO
      do_reset();
      bq.delete();
      for (int i = 0; i < 65; i++) bq.push_back(8'(8'hC0 + (i % 64)));
      push_bytes(bq, k);
      at_edge(k + FRAME);
      check("t4_ovf_before", {31'b0, fifo_overflow}, 32'd0);
      valid = 1'b1;
      data  = 8'h3C;
      @(negedge clk);
      valid = 1'b1;
      data  = 8'h3D;
      @(negedge clk);
      idle_inputs();
      check("t4_ovf_edge", ovf_rise, k + 1 + FRAME);
      at_edge(k + 1 + 2 * FRAME + 5);
      check("t4_ovf_sticky", {31'b0, fifo_overflow}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
